// File: rtl/conv_rd_seq.sv
// Read sequencer for the CONV datapath: walks kernel, channel, output row and
// column pair, issuing kernel-buffer and fmap-buffer read beats with
// downstream back-pressure and accumulator first/last channel flags.
module conv_rd_seq #(
    parameter int KSIZE  = 4,
    parameter int WLANES = 8,
    parameter int FMAP_W = 64,
    parameter int FMAP_H = 64,
    parameter int FLUSH  = 2,
    parameter int WA_W   = 14,
    parameter int FA_W   = 17
) (
    input  logic            clk,
    input  logic            in_rst,
    input  logic            in_start_conv,
    input  logic [1:0]      in_cfg_ci,
    input  logic [1:0]      in_cfg_co,
    input  logic            in_ready,
    output logic            out_readw_ctl,
    output logic            out_readi_ctl,
    output logic [WA_W-1:0] out_waddr,
    output logic [FA_W-1:0] out_faddr,
    output logic            out_first_ch,
    output logic            out_last_ch,
    output logic            out_end_conv
);

    localparam int KK      = KSIZE * KSIZE;
    localparam int WB      = KK / WLANES;
    localparam int FB      = FMAP_W / 2;
    localparam int OR_ROWS = FMAP_H - KSIZE + 1;
    localparam int BW      = $clog2(FB + 1);
    localparam int RW      = (OR_ROWS > 1) ? $clog2(OR_ROWS) : 1;
    localparam int FW      = $clog2(FLUSH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WGT,
        S_FMAP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    kIdx_q, kIdx_d;
    logic [4:0]    chIdx_q, chIdx_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [1:0]    cfgCi_q, cfgCi_d;
    logic [1:0]    cfgCo_q, cfgCo_d;
    logic          startPrev_q;
    logic          startEdge;
    logic [4:0]    lastCh;
    logic [4:0]    lastKn;

    logic            readw_q, readw_d;
    logic            readi_q, readi_d;
    logic [WA_W-1:0] waddr_q, waddr_d;
    logic [FA_W-1:0] faddr_q, faddr_d;
    logic            firstCh_q, firstCh_d;
    logic            lastCh_q, lastCh_d;
    logic            endConv_q, endConv_d;

    int nchInt;
    int wIdx;
    int fIdx;

    // Channel/kernel counts are multiples of 8, so the last index is cfg*8+7.
    assign startEdge = in_start_conv & ~startPrev_q;
    assign lastCh    = {cfgCi_q, 3'b111};
    assign lastKn    = {cfgCo_q, 3'b111};

    // Next-state and position counters; every move through WGT/FMAP waits on in_ready.
    always_comb begin
        state_d = state_q;
        kIdx_d  = kIdx_q;
        chIdx_d = chIdx_q;
        row_d   = row_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        cfgCi_d = cfgCi_q;
        cfgCo_d = cfgCo_q;
        case (state_q)
            S_IDLE: begin
                if (startEdge) begin
                    cfgCi_d = in_cfg_ci;
                    cfgCo_d = in_cfg_co;
                    kIdx_d  = '0;
                    chIdx_d = '0;
                    row_d   = '0;
                    beat_d  = '0;
                    flush_d = '0;
                    state_d = S_WGT;
                end
            end
            S_WGT: begin
                if (in_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(WB - 1)) begin
                        flush_d = '0;
                        state_d = (WB == FB) ? S_FLUSH : S_FMAP;
                    end
                end
            end
            S_FMAP: begin
                if (in_ready) begin
                    if (beat_q == BW'(FB - 1)) begin
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FW'(FLUSH - 1)) begin
                    beat_d  = '0;
                    state_d = S_WGT;
                    if (row_q != RW'(OR_ROWS - 1)) begin
                        row_d = row_q + RW'(1);
                    end else begin
                        row_d = '0;
                        if (chIdx_q != lastCh) begin
                            chIdx_d = chIdx_q + 5'd1;
                        end else begin
                            chIdx_d = '0;
                            if (kIdx_q != lastKn) begin
                                kIdx_d = kIdx_q + 5'd1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Buffer indices for the upcoming position, so the outputs can be registered.
    always_comb begin
        nchInt = (int'(cfgCi_d) + 1) * 8;
        wIdx   = (int'(kIdx_d) * nchInt + int'(chIdx_d)) * KK + int'(beat_d) * WLANES;
        fIdx   = int'(chIdx_d) * FMAP_H * FMAP_W + int'(row_d) * FMAP_W + 2 * int'(beat_d);
    end

    // Output values decoded from the state being entered.
    always_comb begin
        readw_d   = 1'b0;
        readi_d   = 1'b0;
        waddr_d   = '0;
        faddr_d   = '0;
        firstCh_d = 1'b0;
        lastCh_d  = 1'b0;
        endConv_d = 1'b0;
        case (state_d)
            S_WGT: begin
                readw_d   = 1'b1;
                readi_d   = 1'b1;
                waddr_d   = WA_W'(wIdx);
                faddr_d   = FA_W'(fIdx);
                firstCh_d = (chIdx_d == 5'd0);
                lastCh_d  = (chIdx_d == {cfgCi_d, 3'b111});
            end
            S_FMAP: begin
                readi_d   = 1'b1;
                faddr_d   = FA_W'(fIdx);
                firstCh_d = (chIdx_d == 5'd0);
                lastCh_d  = (chIdx_d == {cfgCi_d, 3'b111});
            end
            S_FLUSH: begin
                firstCh_d = (chIdx_d == 5'd0);
                lastCh_d  = (chIdx_d == {cfgCi_d, 3'b111});
            end
            S_DONE: begin
                endConv_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            kIdx_q      <= '0;
            chIdx_q     <= '0;
            row_q       <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            cfgCi_q     <= '0;
            cfgCo_q     <= '0;
            startPrev_q <= 1'b0;
            readw_q     <= 1'b0;
            readi_q     <= 1'b0;
            waddr_q     <= '0;
            faddr_q     <= '0;
            firstCh_q   <= 1'b0;
            lastCh_q    <= 1'b0;
            endConv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kIdx_q      <= kIdx_d;
            chIdx_q     <= chIdx_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            cfgCi_q     <= cfgCi_d;
            cfgCo_q     <= cfgCo_d;
            startPrev_q <= in_start_conv;
            readw_q     <= readw_d;
            readi_q     <= readi_d;
            waddr_q     <= waddr_d;
            faddr_q     <= faddr_d;
            firstCh_q   <= firstCh_d;
            lastCh_q    <= lastCh_d;
            endConv_q   <= endConv_d;
        end
    end

    assign out_readw_ctl = readw_q;
    assign out_readi_ctl = readi_q;
    assign out_waddr     = waddr_q;
    assign out_faddr     = faddr_q;
    assign out_first_ch  = firstCh_q;
    assign out_last_ch   = lastCh_q;
    assign out_end_conv  = endConv_q;

endmodule

// File: doc/conv_rd_seq.md
# conv_rd_seq

- Synthesizable, parametrised read sequencer for the CONV datapath.
- Generates the kernel-buffer and feature-map-buffer read requests and addresses, replacing the hard-coded counter loops the current bench uses to feed the conv top.
- Adds what the bench loops lack: downstream back-pressure, run-time channel/kernel configuration and accumulator-control flags.
- Iteration order, outermost to innermost: kernel, channel, output row, column pair.

## Interface
- KSIZE, 4, kernel edge; KSIZE*KSIZE must be a multiple of WLANES
- WLANES, 8, weights delivered per read beat
- FMAP_W, 64, fmap width; must be even
- FMAP_H, 64, fmap height
- FLUSH, 2, idle cycles after each row pass
- WA_W, 14, weight address width
- FA_W, 17, fmap address width
- clk  in  1  clock
- in_rst  in  1  synchronous, active-high reset
- in_start_conv  in  1  start request; acts on its rising edge while IDLE
- in_cfg_ci  in  2  channel count: NCH=(in_cfg_ci+1)*8; latched at start
- in_cfg_co  in  2  kernel count: NKN=(in_cfg_co+1)*8; latched at start
- in_ready  in  1  downstream accepts the current beat
- out_readw_ctl  out  1  weight read request
- out_readi_ctl  out  1  fmap read request
- out_waddr  out  WA_W  first weight index of the beat
- out_faddr  out  FA_W  fmap index of row r, column 2j; the buffer returns rows r..r+KSIZE-1 at columns 2j and 2j+1
- out_first_ch  out  1  current pass is channel 0 (clear accumulator)
- out_last_ch  out  1  current pass is channel NCH-1 (write result)
- out_end_conv  out  1  one-cycle pulse when the run completes

## Operation
Derived constants:
- WB=KSIZE*KSIZE/WLANES (weight beats)
- FB=FMAP_W/2 (fmap beats)
- OR=FMAP_H-KSIZE+1 (output rows)

Counters: k (kernel), c (channel), r (row), b (beat), f (flush).

Addresses:
- out_waddr = (k*NCH+c)*KSIZE*KSIZE + b*WLANES
- out_faddr = c*FMAP_H*FMAP_W + r*FMAP_W + 2b

States:
- IDLE: all outputs 0. A start edge latches cfg, clears all counters and moves to WGT.
- WGT (b<WB): readw=readi=1. When in_ready=1, b++. After beat WB-1 is accepted, go to FMAP, or to FLUSH if WB==FB.
- FMAP (WB<=b<FB): readi=1, readw=0, out_waddr=0. Advances on in_ready. After beat FB-1 is accepted, go to FLUSH.
- FLUSH: both ctl=0, addresses 0. Counts FLUSH cycles regardless of in_ready, then advances the position:
  - r<OR-1: r++.
  - else r=0; if c<NCH-1, c++.
  - else c=0; if k<NKN-1, k++.
  - else go to DONE.
  - Every path except the final one returns to WGT with b=0.
- DONE: out_end_conv=1 for one cycle, then IDLE.

Rules and boundary conditions:
- While in_ready=0, every output and counter holds. The same beat is re-presented until it is accepted.
- out_first_ch = (c==0) and out_last_ch = (c==NCH-1) hold through the whole pass, FLUSH included. When NCH=8 and c=7, only out_last_ch is 1.
- A start edge outside IDLE is ignored. Changes to in_cfg_* during a run are ignored.
- If in_start_conv is held high through DONE, a new run does not start; it must go low before it can restart.
- in_rst has priority over everything: next state IDLE, counters 0, all outputs 0 on the following edge, mid-run included.

## Timing
- All outputs are registered.
- Start edge sampled at edge N (state IDLE) gives WGT beat 0 on the outputs after edge N; beat 0 is accepted at edge N+1 if in_ready=1.
- With in_ready held at 1, one row pass is FB+FLUSH cycles (34 at defaults).
- Run length with in_ready held at 1 = NKN*NCH*OR*(FB+FLUSH) cycles, then one DONE cycle.
- out_end_conv rises in the cycle after the last FLUSH cycle.
- Every in_ready=0 cycle during WGT or FMAP adds exactly one cycle.

## Test plan
- Reset: assert in_rst mid-row (r=5, b=10) → next cycle all outputs 0, state IDLE. A new start edge then gives waddr=0, faddr=0.
- Row pass, defaults, cfg 0/0, ready=1:
  - cycle0: readw=readi=1, waddr=0, faddr=0
  - cycle1: waddr=8, faddr=2
  - cycle2: readw=0, readi=1, faddr=4
  - cycle31: faddr=62
  - cycles 32–33: both ctl=0
  - cycle34: waddr=0, faddr=64 (r=1)
- Rollover:
  - After r=60 of c=0 → waddr=16, faddr=4096, out_first_ch=0.
  - During c=7 → out_last_ch=1.
  - After k=0 finishes (NCH=8) → waddr=128, faddr=0, out_first_ch=1.
- Stall: in_ready=0 for 3 cycles while faddr=10 → faddr=10 held for 4 cycles, then 12. Row pass measures 37 cycles.
- Completion, cfg 0/0, ready=1:
  - out_end_conv pulses once, 132736 cycles after the start edge.
  - Returns to IDLE.
  - in_start_conv held high does not restart; low-then-high restarts.
- Parameter override WLANES=16, FMAP_W=16, FMAP_H=8, cfg 1/0:
  - WB=1, FB=8, OR=5.
  - readw is high in beat 0 only; waddr steps by 16 per channel.
  - Run = 8*16*5*10 = 6400 cycles.
